// File: rtl/banner_draw_engine.sv
// Full-screen banner renderer: rasters a SCREEN_W x SCREEN_H frame from a tile map into the frame
// buffer through a ROM_LAT-deep pipeline. Optional build macro: TRANSPARENT_KEY_EN.
module banner_draw_engine #(
    parameter int         SCREEN_W  = 320,
    parameter int         SCREEN_H  = 240,
    parameter int         TILE_LOG2 = 5,
    parameter int         MAP_COLS  = 10,
    parameter int         MSG_ROW   = 3,
    parameter int         ID_W      = 3,
    parameter int         ROM_LAT   = 1,
    parameter logic [7:0] KEY_COLOR = 8'hE3,
    localparam int        AW        = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 MAP_WE,
    input  logic [AW-1:0]        MAP_ADDR,
    input  logic [ID_W-1:0]      MAP_DATA,
    input  logic [7:0]           PIXEL_DIN,
    output logic                 RE,
    output logic [ID_W-1:0]      SPRITE_ID,
    output logic [TILE_LOG2-1:0] SPRITE_X,
    output logic [TILE_LOG2-1:0] SPRITE_Y,
    output logic                 WE,
    output logic [8:0]           PIXEL_X,
    output logic [8:0]           PIXEL_Y,
    output logic [7:0]           PIXEL_DOUT,
    output logic                 BUSY,
    output logic                 DONE
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    localparam int              CW            = 9 - TILE_LOG2;
    localparam logic [8:0]      LP_X_LAST     = 9'(SCREEN_W - 1);
    localparam logic [8:0]      LP_Y_LAST     = 9'(SCREEN_H - 1);
    localparam logic [CW-1:0]   LP_MSG_ROW    = CW'(MSG_ROW);
    localparam logic [AW:0]     LP_COLS       = (AW + 1)'(MAP_COLS);
    localparam logic [2:0]      LP_DRAIN_LAST = 3'(ROM_LAT - 1);

    state_t                 r_state;
    logic [8:0]             r_x;
    logic [8:0]             r_y;
    logic [ID_W-1:0]        r_map [MAP_COLS];
    logic                   r_last;
    logic                   r_busy;
    logic                   r_done;
    logic [2:0]             r_drain_cnt;

    logic                   r_vld_p0;
    logic [8:0]             r_x_p0;
    logic [8:0]             r_y_p0;
    logic [ID_W-1:0]        r_sprite_id_p0;
    logic [TILE_LOG2-1:0]   r_sprite_x_p0;
    logic [TILE_LOG2-1:0]   r_sprite_y_p0;

    logic                   r_vld_p [1:ROM_LAT];
    logic [8:0]             r_x_p   [1:ROM_LAT];
    logic [8:0]             r_y_p   [1:ROM_LAT];

    logic [AW-1:0]          w_col;
    logic [CW-1:0]          w_trow;
    logic [ID_W-1:0]        w_id;
    logic                   w_at_end;
    logic                   w_issue;
    logic                   w_we;

    // Message map; out-of-range slot writes are dropped.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            for (int i = 0; i < MAP_COLS; i++) r_map[i] <= '0;
        end else if (MAP_WE && ({1'b0, MAP_ADDR} < LP_COLS)) begin
            r_map[MAP_ADDR] <= MAP_DATA;
        end
    end

    assign w_col    = r_x[TILE_LOG2 +: AW];
    assign w_trow   = r_y[8:TILE_LOG2];
    assign w_id     = (w_trow == LP_MSG_ROW) ? r_map[w_col] : '0;
    assign w_at_end = (r_x == LP_X_LAST) && (r_y == LP_Y_LAST);
    assign w_issue  = ((r_state == S_IDLE) && START) || ((r_state == S_SCAN) && !r_last);

    // Issue stage (p0): raster counters hold the next pixel to request from the ROM.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state        <= S_IDLE;
            r_x            <= '0;
            r_y            <= '0;
            r_last         <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_drain_cnt    <= '0;
            r_vld_p0       <= 1'b0;
            r_x_p0         <= '0;
            r_y_p0         <= '0;
            r_sprite_id_p0 <= '0;
            r_sprite_x_p0  <= '0;
            r_sprite_y_p0  <= '0;
        end else begin
            r_vld_p0 <= w_issue;
            r_done   <= 1'b0;
            if (w_issue) begin
                r_x_p0         <= r_x;
                r_y_p0         <= r_y;
                r_sprite_id_p0 <= w_id;
                r_sprite_x_p0  <= r_x[TILE_LOG2-1:0];
                r_sprite_y_p0  <= r_y[TILE_LOG2-1:0];
                r_last         <= w_at_end;
                if (w_at_end) begin
                    r_x <= '0;
                    r_y <= '0;
                end else if (r_x == LP_X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + 9'd1;
                end else begin
                    r_x <= r_x + 9'd1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state <= S_SCAN;
                        r_busy  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (r_last) begin
                        r_state     <= S_DRAIN;
                        r_last      <= 1'b0;
                        r_drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == LP_DRAIN_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Delay stages p1..pROM_LAT: coordinates travel alongside the ROM access.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            for (int k = 1; k <= ROM_LAT; k++) begin
                r_vld_p[k] <= 1'b0;
                r_x_p[k]   <= '0;
                r_y_p[k]   <= '0;
            end
        end else begin
            r_vld_p[1] <= r_vld_p0;
            r_x_p[1]   <= r_x_p0;
            r_y_p[1]   <= r_y_p0;
            for (int k = 2; k <= ROM_LAT; k++) begin
                r_vld_p[k] <= r_vld_p[k-1];
                r_x_p[k]   <= r_x_p[k-1];
                r_y_p[k]   <= r_y_p[k-1];
            end
        end
    end

`ifdef TRANSPARENT_KEY_EN
    assign w_we = r_vld_p[ROM_LAT] && (PIXEL_DIN != KEY_COLOR);
`else
    assign w_we = r_vld_p[ROM_LAT];
`endif

    assign RE         = r_vld_p0;
    assign SPRITE_ID  = r_sprite_id_p0;
    assign SPRITE_X   = r_sprite_x_p0;
    assign SPRITE_Y   = r_sprite_y_p0;
    assign WE         = w_we;
    assign PIXEL_X    = r_x_p[ROM_LAT];
    assign PIXEL_Y    = r_y_p[ROM_LAT];
    assign PIXEL_DOUT = r_vld_p[ROM_LAT] ? PIXEL_DIN : 8'h00;
    assign BUSY       = r_busy;
    assign DONE       = r_done;

endmodule

// File: tb/tb_banner_draw_engine.sv
// Self-checking bench for banner_draw_engine: directed frame draws with a behavioural raster model.
module tb_banner_draw_engine;

    localparam int         W    = 64;
    localparam int         H    = 32;
    localparam int         T    = 4;
    localparam int         TM   = (1 << T) - 1;
    localparam int         COLS = 4;
    localparam int         MROW = 1;
    localparam int         IDW  = 3;
    localparam int         LAT  = 2;
    localparam logic [7:0] KEY  = 8'hE3;

    logic           CLOCK_50 = 1'b0;
    logic           RESET    = 1'b1;
    logic           START    = 1'b0;
    logic           MAP_WE   = 1'b0;
    logic [1:0]     MAP_ADDR = '0;
    logic [IDW-1:0] MAP_DATA = '0;
    logic [7:0]     PIXEL_DIN;
    logic           RE, WE, BUSY, DONE;
    logic [IDW-1:0] SPRITE_ID;
    logic [T-1:0]   SPRITE_X, SPRITE_Y;
    logic [8:0]     PIXEL_X, PIXEL_Y;
    logic [7:0]     PIXEL_DOUT;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mmap [COLS];
    logic [7:0] rom_q [LAT] = '{default: 8'h00};

    banner_draw_engine #(
        .SCREEN_W(W), .SCREEN_H(H), .TILE_LOG2(T), .MAP_COLS(COLS),
        .MSG_ROW(MROW), .ID_W(IDW), .ROM_LAT(LAT), .KEY_COLOR(KEY)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .START(START),
        .MAP_WE(MAP_WE), .MAP_ADDR(MAP_ADDR), .MAP_DATA(MAP_DATA),
        .PIXEL_DIN(PIXEL_DIN), .RE(RE), .SPRITE_ID(SPRITE_ID),
        .SPRITE_X(SPRITE_X), .SPRITE_Y(SPRITE_Y), .WE(WE),
        .PIXEL_X(PIXEL_X), .PIXEL_Y(PIXEL_Y), .PIXEL_DOUT(PIXEL_DOUT),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // ROM: answers every request with {0, sprite id, tile row} LAT cycles later.
    always @(posedge CLOCK_50) begin
`ifdef TRANSPARENT_KEY_EN
        rom_q[0] <= (SPRITE_ID == '0) ? KEY : {1'b0, SPRITE_ID, SPRITE_Y};
`else
        rom_q[0] <= {1'b0, SPRITE_ID, SPRITE_Y};
`endif
        for (int k = 1; k < LAT; k++) rom_q[k] <= rom_q[k-1];
    end
    assign PIXEL_DIN = rom_q[LAT-1];

    function automatic int id_of(input int x, input int y);
        return ((y >> T) == MROW) ? mmap[x >> T] : 0;
    endfunction

    function automatic bit written(input int x, input int y);
`ifdef TRANSPARENT_KEY_EN
        return id_of(x, y) != 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        cyc++;
    endtask

    task automatic map_write(input int a, input int d);
        MAP_WE   = 1'b1;
        MAP_ADDR = 2'(a);
        MAP_DATA = 3'(d);
        tick();
        MAP_WE   = 1'b0;
        mmap[a]  = d;
    endtask

    task automatic run_draw(input string tag, input bit spam, input int wr_cyc, input int abort_we);
        int re_n, we_n, busy_n, done_n, done_cyc, first_we, p, first_idx, exp_total;
        int order_err, sprite_err, data_err, sid_a, sid_b, x, y, ex, ey, exp_data, act;
        bit aborted;
        re_n = 0; we_n = 0; busy_n = 0; done_n = 0; done_cyc = -1; first_we = -1; p = 0;
        order_err = 0; sprite_err = 0; data_err = 0; sid_a = -1; sid_b = -1; aborted = 1'b0;
        cyc   = 0;
        START = 1'b1;
        tick();
        START = spam;
        for (int n = 0; n < W * H + LAT + 8; n++) begin
            if (RE === 1'b1) begin
                x = re_n % W;
                y = re_n / W;
                if (int'(SPRITE_X) != (x & TM) || int'(SPRITE_Y) != (y & TM) ||
                    int'(SPRITE_ID) != id_of(x, y)) sprite_err++;
                if (x == 40 && y == 20) sid_a = int'(SPRITE_ID);
                if (x == 5 && y == 20) sid_b = int'(SPRITE_ID);
                re_n++;
            end
            if (WE === 1'b1) begin
                if (first_we < 0) first_we = cyc;
                while (p < W * H && !written(p % W, p / W)) p++;
                ex = p % W;
                ey = p / W;
                exp_data = (id_of(ex, ey) << T) | (ey & TM);
                if (int'(PIXEL_X) != ex || int'(PIXEL_Y) != ey) order_err++;
                if (int'(PIXEL_DOUT) != exp_data) data_err++;
                p++;
                we_n++;
            end
            if (BUSY === 1'b1) busy_n++;
            if (DONE === 1'b1) begin
                done_n++;
                done_cyc = cyc;
            end
            if (abort_we > 0 && we_n == abort_we) begin
                aborted = 1'b1;
                break;
            end
            START    = spam && (done_n == 0 || DONE === 1'b1);
            MAP_WE   = (cyc == wr_cyc);
            MAP_ADDR = '0;
            MAP_DATA = 3'd5;
            if (cyc == wr_cyc) mmap[0] = 5;
            tick();
        end
        START  = 1'b0;
        MAP_WE = 1'b0;

        if (abort_we > 0) begin
            chk({tag, "_reached_abort_point"}, int'(aborted), 1);
            RESET = 1'b1;
            tick();
            chk({tag, "_we_after_reset"}, int'(WE), 0);
            chk({tag, "_busy_after_reset"}, int'(BUSY), 0);
            RESET = 1'b0;
            act = 0;
            for (int n = 0; n < 60; n++) begin
                tick();
                if (WE !== 1'b0 || DONE !== 1'b0 || RE !== 1'b0) act++;
            end
            chk({tag, "_activity_after_abort"}, act, 0);
            for (int i = 0; i < COLS; i++) mmap[i] = 0;
        end else begin
            exp_total = 0;
            first_idx = -1;
            for (int i = 0; i < W * H; i++) begin
                if (written(i % W, i / W)) begin
                    exp_total++;
                    if (first_idx < 0) first_idx = i;
                end
            end
            chk({tag, "_re_count"}, re_n, W * H);
            chk({tag, "_we_count"}, we_n, exp_total);
            chk({tag, "_write_order_errs"}, order_err, 0);
            chk({tag, "_pixel_data_errs"}, data_err, 0);
            chk({tag, "_sprite_errs"}, sprite_err, 0);
            chk({tag, "_busy_cycles"}, busy_n, W * H + LAT);
            chk({tag, "_done_count"}, done_n, 1);
            chk({tag, "_done_cycle"}, done_cyc, W * H + LAT + 1);
            chk({tag, "_first_we_cycle"}, first_we, 1 + LAT + first_idx);
            chk({tag, "_sid_40_20"}, sid_a, id_of(40, 20));
            chk({tag, "_sid_5_20"}, sid_b, id_of(5, 20));
        end
    endtask

    initial begin
        int act;
        for (int i = 0; i < COLS; i++) mmap[i] = 0;

        RESET = 1'b1;
        tick(); tick(); tick();
        chk("rst_re", int'(RE), 0);
        chk("rst_we", int'(WE), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_pixel_x", int'(PIXEL_X), 0);
        chk("rst_pixel_y", int'(PIXEL_Y), 0);
        chk("rst_pixel_dout", int'(PIXEL_DOUT), 0);
        chk("rst_sprite", int'({SPRITE_ID, SPRITE_X, SPRITE_Y}), 0);
        RESET = 1'b0;

        act = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (RE !== 1'b0 || WE !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) act++;
        end
        chk("idle_activity", act, 0);

        for (int i = 0; i < COLS; i++) map_write(i, i + 1);
        run_draw("frame", 1'b0, 0, 0);

        run_draw("middraw", 1'b0, 10 * W + 1, 0);
        map_write(0, 1);

        run_draw("spam", 1'b1, 0, 0);

        run_draw("abort", 1'b0, 0, 1000);

        for (int i = 0; i < COLS; i++) map_write(i, i + 1);
        run_draw("after_abort", 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
